// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: slice operation selects and
// controller state.
package alu_pkg;

  // Full 4-bit selects understood by the single-bit slice.
  localparam logic [3:0] SEL_PASS = 4'b0000;
  localparam logic [3:0] SEL_ADD  = 4'b0001;
  localparam logic [3:0] SEL_SUB  = 4'b0010;
  localparam logic [3:0] SEL_DEC  = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_OR   = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0110;
  localparam logic [3:0] SEL_NOT  = 4'b0111;

  // Shifts are identified by sel[3:2] alone; sel[1:0] is ignored for them.
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_SHL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for the ops whose final carry is reported on cout.
  function automatic logic is_arith(input logic [3:0] sel);
    return (sel[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// Combinational one-bit ALU slice: arithmetic with ripple carry and bitwise
// logic. Shift selects are not handled here and produce 0.
module alu_1bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [3:0] sel_i,
  output logic       f_o,
  output logic       cout_o
);

  logic b_inv;

  always_comb begin
    f_o    = 1'b0;
    cout_o = 1'b0;
    b_inv  = ~b_i;
    case (sel_i)
      SEL_PASS: f_o = a_i;
      SEL_ADD: begin
        f_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
      end
      // A + ~B + cin: a true subtract needs cin=1.
      SEL_SUB: begin
        f_o    = a_i ^ b_inv ^ cin_i;
        cout_o = (a_i & b_inv) | (cin_i & (a_i ^ b_inv));
      end
      // A + all-ones + cin: decrement when cin=0, pass-through when cin=1.
      SEL_DEC: begin
        f_o    = ~(a_i ^ cin_i);
        cout_o = a_i | cin_i;
      end
      SEL_AND: f_o = a_i & b_i;
      SEL_OR:  f_o = a_i | b_i;
      SEL_XOR: f_o = a_i ^ b_i;
      SEL_NOT: f_o = ~a_i;
      default: begin
        f_o    = 1'b0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: feeds one operand bit per clock (LSB first) through
// a single alu_1bit slice and returns the full-width result over valid/ready.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  input  logic             cin_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       sel_q, sel_d;
  logic             carry_q, carry_d;
  logic             prev_a_q, prev_a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             slice_f;
  logic             slice_cout;
  logic             res_bit;
  logic             is_shift;

  // Operand registers shift right each step, so bit 0 is always the current
  // bit and bit 1 is the next one (zero-filled past the MSB).
  alu_1bit u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sel_i  (sel_q),
    .f_o    (slice_f),
    .cout_o (slice_cout)
  );

  always_comb begin
    is_shift = sel_q[3];
    case (sel_q[3:2])
      SEL_SHR: res_bit = a_q[1];
      SEL_SHL: res_bit = prev_a_q;
      default: res_bit = slice_f;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    sel_d       = sel_q;
    carry_d     = carry_q;
    prev_a_d    = prev_a_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    cout_d      = cout_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          sel_d    = sel_i;
          carry_d  = cin_i;
          prev_a_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        result_d = {res_bit, result_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        prev_a_d = a_q[0];
        if (!is_shift) begin
          carry_d = slice_cout;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d       = '0;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
          cout_d      = is_arith(sel_q) ? carry_d : 1'b0;
          zero_d      = (result_d == '0);
          state_d     = DONE;
        end
      end

      DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      sel_q       <= '0;
      carry_q     <= 1'b0;
      prev_a_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      sel_q       <= sel_d;
      carry_q     <= carry_d;
      prev_a_q    <= prev_a_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
    end
  end

  // Ready is decoded from state so it drops in the same cycle RUN begins.
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;
  assign f_o         = result_q;
  assign cout_o      = cout_q;
  assign zero_o      = zero_q;

  a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(f_o)));

  a_busy_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(busy_o && rsp_valid_o));

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: arithmetic, logic, shifts, latency,
// response backpressure and asynchronous reset in the middle of an operation.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] f;
  logic         cout;
  logic         zero;
  logic         busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a),
    .b_i         (b),
    .sel_i       (sel),
    .cin_i       (cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .f_o         (f),
    .cout_o      (cout),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  // Issue a request, scramble the inputs after the handshake, wait for the
  // response and report what was seen. Leaves the response pending.
  task automatic issue_and_wait(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic [3:0] si, input logic ci,
                                output int lat, output int busy_cnt);
    a = ai; b = bi; sel = si; cin = ci; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = $urandom; b = $urandom; sel = 4'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) break;
      if (busy) busy_cnt++;
    end
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL rsp_timeout got rsp_valid=%0b after %0d cycles, need 1", rsp_valid, lat);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [3:0] si, input logic ci,
                       output logic [W-1:0] fo, output logic co, output logic zo,
                       output int lat, output int busy_cnt);
    issue_and_wait(ai, bi, si, ci, lat, busy_cnt);
    fo = f; co = cout; zo = zero;
    $display("op sel=%b a=%h b=%h cin=%0b -> f=%h cout=%0b zero=%0b lat=%0d",
             si, ai, bi, ci, fo, co, zo, lat);
    release_rsp();
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b need=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b need=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b need=0", busy); end
    total++; if ({f, cout, zero} !== {32'h0, 1'b0, 1'b0}) begin bad++; $display("FAIL reset_outs got f=%h c=%0b z=%0b need 0", f, cout, zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    do_op(32'h5, 32'h3, SEL_ADD, 1'b0, fo, co, zo, lat, bc);
    total++; if (fo !== 32'h8) begin bad++; $display("FAIL add_f got=%h need=%h", fo, 32'h8); end
    total++; if ({co, zo} !== 2'b00) begin bad++; $display("FAIL add_flags got c=%0b z=%0b need 0 0", co, zo); end
    total++; if (lat != 32) begin bad++; $display("FAIL add_latency got=%0d need=32", lat); end
    total++; if (bc != 32) begin bad++; $display("FAIL add_busy_cycles got=%0d need=32", bc); end
    do_op(32'h1234_5678, 32'hFFFF_0000, SEL_PASS, 1'b0, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'h1234_5678, 1'b0}) begin bad++; $display("FAIL pass got f=%h c=%0b need 12345678 0", fo, co); end
  endtask

  task automatic test_sub();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    do_op(32'h5, 32'h5, SEL_SUB, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co, zo} !== {32'h0, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_eq got f=%h c=%0b z=%0b need 0 1 1", fo, co, zo); end
    do_op(32'h3, 32'h5, SEL_SUB, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co, zo} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_neg got f=%h c=%0b z=%0b need fffffffe 0 0", fo, co, zo); end
  endtask

  task automatic test_dec();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    do_op(32'h0, 32'h0, SEL_DEC, 1'b0, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'hFFFF_FFFF, 1'b0}) begin bad++; $display("FAIL dec_zero got f=%h c=%0b need ffffffff 0", fo, co); end
    do_op(32'h1, 32'h0, SEL_DEC, 1'b0, fo, co, zo, lat, bc);
    total++; if ({fo, co, zo} !== {32'h0, 1'b1, 1'b1}) begin bad++; $display("FAIL dec_one got f=%h c=%0b z=%0b need 0 1 1", fo, co, zo); end
    do_op(32'h1234, 32'h0, SEL_DEC, 1'b1, fo, co, zo, lat, bc);
    total++; if (fo !== 32'h1234) begin bad++; $display("FAIL dec_cin got f=%h need 00001234", fo); end
  endtask

  task automatic test_logic();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    logic [3:0]   sels [4] = '{SEL_AND, SEL_OR, SEL_XOR, SEL_NOT};
    logic [W-1:0] exps [4] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0F0F_0F0F};
    for (int i = 0; i < 4; i++) begin
      do_op(32'hF0F0_F0F0, 32'hFF00_FF00, sels[i], 1'b1, fo, co, zo, lat, bc);
      total++; if ({fo, co} !== {exps[i], 1'b0}) begin bad++; $display("FAIL logic_%0d got f=%h c=%0b need %h 0", i, fo, co, exps[i]); end
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    do_op(32'h8000_0001, 32'h0, 4'b1011, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'h4000_0000, 1'b0}) begin bad++; $display("FAIL shr got f=%h c=%0b need 40000000 0", fo, co); end
    do_op(32'h8000_0001, 32'h0, 4'b1101, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'h0000_0002, 1'b0}) begin bad++; $display("FAIL shl got f=%h c=%0b need 00000002 0", fo, co); end
    do_op(32'h8000_0000, 32'h0, 4'b1100, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co, zo} !== {32'h0, 1'b0, 1'b1}) begin bad++; $display("FAIL shl_out got f=%h c=%0b z=%0b need 0 0 1", fo, co, zo); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    do_op(32'h7FFF_FFFF, 32'h1, SEL_ADD, 1'b0, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'h8000_0000, 1'b0}) begin bad++; $display("FAIL b2b_first got f=%h c=%0b need 80000000 0", fo, co); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b need=1", req_ready); end
    do_op(32'h8000_0000, 32'h8000_0001, SEL_ADD, 1'b1, fo, co, zo, lat, bc);
    total++; if ({fo, co} !== {32'h0000_0002, 1'b1}) begin bad++; $display("FAIL b2b_second got f=%h c=%0b need 00000002 1", fo, co); end
  endtask

  task automatic test_backpressure_reset();
    logic [W-1:0] fo; logic co, zo; int lat, bc;
    logic [W-1:0] held;
    issue_and_wait(32'h7, 32'h9, SEL_ADD, 1'b0, lat, bc);
    held = f;
    total++; if (held !== 32'h10) begin bad++; $display("FAIL bp_result got=%h need=00000010", held); end
    for (int i = 0; i < 10; i++) begin
      req_valid = (i == 4);
      a = 32'hDEAD_BEEF; b = 32'h1; sel = SEL_ADD;
      @(posedge clk);
      #1;
      total++; if (f !== held || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got f=%h v=%0b rdy=%0b need %h 1 0", i, f, rsp_valid, req_ready, held);
      end
    end
    req_valid = 1'b0;
    release_rsp();
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ignored got busy=%0b v=%0b rdy=%0b need 0 0 1", busy, rsp_valid, req_ready);
    end
    $display("op backpressure held f=%h for 10 cycles", held);
    // Abort a subtract part-way through RUN.
    a = 32'h5; b = 32'h3; sel = SEL_SUB; cin = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({rsp_valid, busy, cout, zero} !== 4'b0000 || f !== 32'h0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got v=%0b b=%0b c=%0b z=%0b f=%h rdy=%0b need all 0, rdy 1",
                      rsp_valid, busy, cout, zero, f, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got v=%0b b=%0b need 0 0", rsp_valid, busy); end
    do_op(32'hFFFF_FFFF, 32'h1, SEL_ADD, 1'b0, fo, co, zo, lat, bc);
    total++; if ({fo, co, zo} !== {32'h0, 1'b1, 1'b1}) begin bad++; $display("FAIL post_reset_add got f=%h c=%0b z=%0b need 0 1 1", fo, co, zo); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_dec();
    test_logic();
    test_shift();
    test_back_to_back();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Sequencer that runs full-width ALU operations through the existing single-bit slice alu_1bit, one bit per clock, LSB first.
- Carries the ripple carry between bits in a register.
- Takes requests over a valid/ready handshake and returns the WIDTH-bit result, carry-out and zero flag over a second valid/ready handshake.
- Serves as the area-minimal alternative to the full 32-bit ALU and as a golden sequencing model for it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  controller can accept a request; high only in IDLE.
- a_i  input  WIDTH  operand A; sampled on request handshake.
- b_i  input  WIDTH  operand B; sampled on request handshake.
- sel_i  input  4  operation select, same encoding as alu_1bit; sampled on handshake.
- cin_i  input  1  initial carry-in; sampled on handshake.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- f_o  output  WIDTH  result.
- cout_o  output  1  final carry-out for arithmetic ops; 0 otherwise.
- zero_o  output  1  f_o == 0.
- busy_o  output  1  state is RUN.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State goes to IDLE; counter, carry, operand and result registers clear.
  - rsp_valid_o=0, f_o=0, cout_o=0, zero_o=0, busy_o=0.
  - req_ready_o=1, decoded from state.
  - Reset mid-RUN or mid-DONE abandons the operation; no response is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch a_i, b_i, sel_i, cin_i; set carry=cin_i, cnt=0, prev_a=0; go to RUN.
- RUN (exactly WIDTH cycles):
  - Step i presents A[i], B[i], carry and the latched sel to alu_1bit.
  - Result bit i is selected by sel[3:2]:
    - 0x: slice f_o. Carry register <= slice cout_o.
    - 10 (logical shift right): A[i+1], with 0 at i=WIDTH-1.
    - 11 (logical shift left): A[i-1] via prev_a, with 0 at i=0.
  - Slice is not used for shifts; its cout is ignored there.
  - Result shift register fills MSB-first-in, ending LSB-aligned.
  - At cnt==WIDTH-1, go to DONE.
- DONE:
  - rsp_valid_o=1. f_o, cout_o and zero_o are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i: go to IDLE.
  - req_ready_o=0, so requests are never accepted in the same cycle as response completion.
- Latency:
  - Request handshake at edge k; rsp_valid_o rises after edge k+WIDTH.
  - Minimum spacing between accepted requests is WIDTH+2 cycles.
- Flags:
  - cout_o = final carry only for sel 0000..0011; 0 for logic (0100..0111) and shifts.
  - zero_o is computed from the full result in DONE for every op.
- Carry use:
  - cin is ignored for logic and shift ops.
  - Arithmetic wraps modulo 2^WIDTH; the carry beyond bit WIDTH-1 appears only on cout_o.
- Don't-care sel bits: sel[1:0] is don't-care for shifts; decoding uses sel[3:2] only.
- Input stability: a_i, b_i, sel_i and cin_i may change freely after the handshake; the latched copies are used.
- f_o, cout_o and zero_o are registered outputs; their values outside DONE are unspecified.

Decomposition:
- Package alu_pkg holds:
  - sel encodings: SEL_PASS=4'b0000, SEL_ADD=4'b0001, SEL_SUB=4'b0010, SEL_DEC=4'b0011, SEL_AND=4'b0100, SEL_OR=4'b0101, SEL_XOR=4'b0110, SEL_NOT=4'b0111, SEL_SHR=2'b10 (sel[3:2]), SEL_SHL=2'b11.
  - Controller state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module: the existing alu_1bit, instantiated once. No other hierarchy.

Test Plan:
- Add: A=0x00000005, B=0x00000003, sel=0001, cin=0.
  - f=0x00000008, cout=0, zero=0.
  - rsp_valid_o rises exactly 32 cycles after the accept edge; busy_o high for exactly 32 cycles.
- Subtract: A=5, B=5, sel=0010, cin=1 -> f=0, cout=1, zero=1.
  - Then A=3, B=5 -> f=0xFFFFFFFE, cout=0.
- Decrement: A=0, sel=0011, cin=0 -> f=0xFFFFFFFF, cout=0.
  - A=1 -> f=0, cout=1, zero=1.
  - sel=0011, cin=1, A=0x1234 -> f=0x1234.
- Logic: A=0xF0F0F0F0, B=0xFF00FF00, cin=1.
  - AND -> 0xF000F000; OR -> 0xFFF0FFF0; XOR -> 0x0FF00FF0; NOT -> 0x0F0F0F0F.
  - cout=0 in all cases.
- Shifts: A=0x80000001.
  - sel=1011 -> 0x40000000.
  - sel=1101 -> 0x00000002.
  - A=0x80000000, shl -> f=0, zero=1, cout=0.
- Backpressure and reset: rsp_ready_i low for 10 cycles in DONE.
  - f_o stays stable, req_ready_o=0, and a pulsed req_valid_i is ignored.
  - Then rst_ni pulsed low at RUN step 7: all outputs clear immediately and req_ready_o=1.
  - After release, the next add of 0xFFFFFFFF+1 -> f=0, cout=1, zero=1.
